decode: RTL
===========

// Module: decode
// PURPOSE
//  RV32I decode stage; drives the execute stage's input bundle. Accepts {instr, pc} from fetch over
//  valid/ready, reads rs1/rs2 from the register file, and latches operands, flags and immediates into
//  one output pipeline register. A 32-entry busy scoreboard stalls on RAW/WAW hazards until writeback.
// PARAMETERS
//  XLEN  32  datapath / operand width
//  NREG  32  architectural registers; x0 is never busy
// PORTS
//  clk          in   1     clock, rising edge
//  reset        in   1     asynchronous, active-high
//  in_valid     in   1     fetch presents instr/pc
//  in_ready     out  1     decode accepts this cycle
//  instr        in   32    instruction word
//  pc           in   XLEN  address of instr
//  rs1_addr     out  5     regfile read addr = instr[19:15] (combinational)
//  rs2_addr     out  5     regfile read addr = instr[24:20] (combinational)
//  rs1_data     in   XLEN  async regfile read data
//  rs2_data     in   XLEN  async regfile read data
//  out_valid    out  1     output register holds an instruction
//  out_ready    in   1     execute consumes this cycle
//  flush        in   1     discard held instruction (taken branch / jump)
//  wb_valid     in   1     writeback retires wb_dest
//  wb_dest      in   5     register being written back
//  is_load, is_store, is_branch, is_jump, is_reg, is_alu  out 1 each  execute class flags
//  operand_a    out  XLEN  see operand table
//  operand_b    out  XLEN  see operand table
//  branch_dest  out  XLEN  B-immediate, sign-extended (pc-relative offset)
//  store_data   out  XLEN  rs2 value for stores, else 0
//  dest         out  5     rd; 0 for branch/store/illegal
//  func3        out  3     instr[14:12]; 000 for LUI/AUIPC/JAL
//  func7        out  1     instr[30] for OP and SRAI/SRLI; 0 otherwise
//  curr_pc      out  XLEN  latched pc
//  illegal      out  1     unknown opcode; sticky until reset
// BEHAVIOUR
//  - Reset (async): out_valid=0, every data output=0, scoreboard cleared, illegal=0.
//  - Accept = in_valid & in_ready; in_ready = (!out_valid | out_ready) & !hazard & !flush & !illegal.
//  - Latency 1: on accept, the output register loads at the next edge; out_valid=1.
//    If out_valid & out_ready & !accept, out_valid drops to 0. Outputs hold while out_valid & !out_ready.
//  - Operand table (rs = regfile data, imm sign-extended):
//    OP      is_alu  a=rs1 b=rs2      OP-IMM  is_alu  a=rs1 b=I-imm (func7 forced 0 unless f3=101)
//    LUI     is_alu  a=0   b=U-imm    AUIPC   is_alu  a=pc  b=U-imm
//    JAL     is_jump a=J-imm b=0      JALR    is_jump,is_reg a=rs1 b=I-imm
//    BRANCH  is_branch a=rs1 b=rs2, branch_dest=B-imm
//    LOAD    is_load a=rs1 b=I-imm    STORE   is_store a=rs1 b=S-imm store_data=rs2
//  - Illegal opcode: latch illegal=1, out_valid=0, all flags 0, in_ready=0 until reset.
//  - Scoreboard busy[31:0]: on accept of a writer (OP,OP-IMM,LUI,AUIPC,JAL,JALR,LOAD) with rd!=0,
//    set busy[rd]. wb_valid clears busy[wb_dest]. Same-cycle set and clear of one register: set wins.
//  - hazard = (rs1 used & busy[rs1]) | (rs2 used & busy[rs2]) | (writer & busy[rd]). Source x0 is never
//    a hazard. No forwarding: a clear by wb in cycle N unblocks acceptance in cycle N+1.
//  - flush: out_valid<=0 next edge, busy[dest] of the held instruction cleared, no accept that cycle.
//    flush takes priority over out_ready and wb for that register.
//  - Reset asserted mid-stall or mid-hold: everything returns to reset state immediately; pending
//    writebacks after reset are ignored by the empty scoreboard (clear of a non-busy reg is a no-op).
// TESTING
//  1 reset: assert reset 1 cycle -> out_valid=0, dest=0, operand_a=0, curr_pc=0, in_ready=1.
//  2 beq x1,x2,+20 @pc=20, rs1=rs2=200 -> is_branch=1, a=b=200, branch_dest=20, dest=0, curr_pc=20.
//  3 jalr x11,16(x5) @pc=4, rs1=32 -> is_jump=is_reg=1, a=32, b=16, dest=11, busy[11]=1.
//  4 sub x10,x3,x4, then add x9,x10,x1 -> 2nd stalls (in_ready=0) until wb_valid,wb_dest=10; accept next cycle.
//  5 addi x9,x0,-200 with out_ready=0 for 3 cycles -> outputs stable, b=0xFFFFFF38, func7=0, in_ready=0.
//  6 lui x31 held then flush=1 -> out_valid=0 next edge, busy[31]=0; opcode 0x7F -> illegal=1, in_ready=0.

Source files
------------

// File: rtl/decode.sv
// rtl/decode.sv - RV32I decode stage: operand select, class flags, immediates, busy scoreboard
// and a single output pipeline register feeding execute.
module decode #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  input  logic            flush,
  input  logic            wb_valid,
  input  logic [4:0]      wb_dest,
  output logic            is_load,
  output logic            is_store,
  output logic            is_branch,
  output logic            is_jump,
  output logic            is_reg,
  output logic            is_alu,
  output logic [XLEN-1:0] operand_a,
  output logic [XLEN-1:0] operand_b,
  output logic [XLEN-1:0] branch_dest,
  output logic [XLEN-1:0] store_data,
  output logic [4:0]      dest,
  output logic [2:0]      func3,
  output logic            func7,
  output logic [XLEN-1:0] curr_pc,
  output logic            illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  logic [4:0]      rd;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic            d_load, d_store, d_branch, d_jump, d_reg, d_alu, d_f7, d_bad;
  logic            use1, use2, writer, hazard, accept;
  logic [XLEN-1:0] d_a, d_b, d_bd, d_sd;
  logic [4:0]      d_dest;
  logic [2:0]      d_f3;
  logic [NREG-1:0] busy, busy_next;

  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];
  assign rd       = instr[11:7];

  assign imm_i = XLEN'(signed'(instr[31:20]));
  assign imm_s = XLEN'(signed'({instr[31:25], instr[11:7]}));
  assign imm_b = XLEN'(signed'({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
  assign imm_u = XLEN'(signed'({instr[31:12], 12'b0}));
  assign imm_j = XLEN'(signed'({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));

  always_comb begin
    d_load = 1'b0; d_store = 1'b0; d_branch = 1'b0; d_jump = 1'b0;
    d_reg = 1'b0; d_alu = 1'b0; d_f7 = 1'b0; d_bad = 1'b0;
    use1 = 1'b0; use2 = 1'b0; writer = 1'b0;
    d_a = '0; d_b = '0; d_bd = '0; d_sd = '0;
    d_dest = rd;
    d_f3 = instr[14:12];
    case (instr[6:0])
      OPC_OP: begin
        d_alu = 1'b1; writer = 1'b1; use1 = 1'b1; use2 = 1'b1;
        d_a = rs1_data; d_b = rs2_data; d_f7 = instr[30];
      end
      OPC_OP_IMM: begin
        // instr[30] only carries meaning for the shift-right immediates
        d_alu = 1'b1; writer = 1'b1; use1 = 1'b1;
        d_a = rs1_data; d_b = imm_i; d_f7 = (instr[14:12] == 3'b101) & instr[30];
      end
      OPC_LUI: begin
        d_alu = 1'b1; writer = 1'b1; d_b = imm_u; d_f3 = 3'b000;
      end
      OPC_AUIPC: begin
        d_alu = 1'b1; writer = 1'b1; d_a = pc; d_b = imm_u; d_f3 = 3'b000;
      end
      OPC_JAL: begin
        d_jump = 1'b1; writer = 1'b1; d_a = imm_j; d_f3 = 3'b000;
      end
      OPC_JALR: begin
        d_jump = 1'b1; d_reg = 1'b1; writer = 1'b1; use1 = 1'b1;
        d_a = rs1_data; d_b = imm_i;
      end
      OPC_BRANCH: begin
        d_branch = 1'b1; use1 = 1'b1; use2 = 1'b1;
        d_a = rs1_data; d_b = rs2_data; d_bd = imm_b; d_dest = 5'd0;
      end
      OPC_LOAD: begin
        d_load = 1'b1; writer = 1'b1; use1 = 1'b1; d_a = rs1_data; d_b = imm_i;
      end
      OPC_STORE: begin
        d_store = 1'b1; use1 = 1'b1; use2 = 1'b1;
        d_a = rs1_data; d_b = imm_s; d_sd = rs2_data; d_dest = 5'd0;
      end
      default: begin
        d_bad = 1'b1; d_dest = 5'd0; d_f3 = 3'b000;
      end
    endcase
  end

  assign hazard = (use1 & (rs1_addr != 5'd0) & busy[rs1_addr])
                | (use2 & (rs2_addr != 5'd0) & busy[rs2_addr])
                | (writer & (rd != 5'd0) & busy[rd]);
  assign in_ready = (~out_valid | out_ready) & ~hazard & ~flush & ~illegal;
  assign accept   = in_valid & in_ready;

  // Set is applied last so a same-cycle writeback of the new destination loses.
  always_comb begin
    busy_next = busy;
    if (wb_valid) busy_next[wb_dest] = 1'b0;
    if (flush && out_valid) busy_next[dest] = 1'b0;
    if (accept && writer) busy_next[rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0; out_valid <= 1'b0; illegal <= 1'b0;
      is_load <= 1'b0; is_store <= 1'b0; is_branch <= 1'b0;
      is_jump <= 1'b0; is_reg <= 1'b0; is_alu <= 1'b0;
      operand_a <= '0; operand_b <= '0; branch_dest <= '0; store_data <= '0;
      dest <= '0; func3 <= '0; func7 <= 1'b0; curr_pc <= '0;
    end else begin
      busy <= busy_next;
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= ~d_bad;
        illegal <= illegal | d_bad;
        is_load <= d_load; is_store <= d_store; is_branch <= d_branch;
        is_jump <= d_jump; is_reg <= d_reg; is_alu <= d_alu;
        operand_a <= d_a; operand_b <= d_b; branch_dest <= d_bd; store_data <= d_sd;
        dest <= d_dest; func3 <= d_f3; func7 <= d_f7; curr_pc <= pc;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
